mar_burst: RTL and testbench
============================

// Module: mar_burst
// PURPOSE
//  Parametrised memory address register with step and burst modes. Points the
//  data memory at an address for reads and writes.
//  - Loads from C_bus, or steps up or down by STRIDE.
//  - Runs an autonomous burst of N accesses, advancing the address on each
//    memory acknowledge.
//  - Sits between the C_bus and the data memory address input.
// PARAMETERS
//  ADDR_W   24  address width (data_addr, C_bus)
//  LEN_W    8   burst length counter width
//  STRIDE   1   address step for inc/dec and burst advance; 1..2**ADDR_W-1
//  WRAP_EN  1   1: address arithmetic wraps mod 2**ADDR_W; 0: saturate and flag err
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous reset, active-high
//  load         in   1       data_addr <= C_bus (IDLE only)
//  inc          in   1       data_addr += STRIDE (IDLE only)
//  dec          in   1       data_addr -= STRIDE (IDLE only)
//  C_bus        in   ADDR_W  load value / burst base address
//  burst_start  in   1       start a burst of burst_len accesses (IDLE only)
//  burst_len    in   LEN_W   number of accesses in burst; 0 = request ignored
//  mem_ack      in   1       memory accepted the access at data_addr this cycle
//  data_addr    out  ADDR_W  current memory address (registered)
//  mem_req      out  1       burst access request; high for the whole of BURST
//  busy         out  1       high in BURST
//  done         out  1       one-cycle pulse, the cycle after the final burst ack
//  err          out  1       sticky over/underflow flag (WRAP_EN=0 only)
// BEHAVIOUR
//  Reset (rst=1 at posedge, overrides everything):
//   - data_addr=0, busy=0, mem_req=0, done=0, err=0
//   - state=IDLE, remaining count=0
//   - reset mid-burst aborts the burst; no done pulse
//  States: IDLE, BURST. mem_req = busy = (state==BURST), decoded from the state register.
//  IDLE, per cycle (priority high to low):
//   - burst_start && burst_len!=0: state->BURST, remaining<=burst_len. Base address:
//     - if load is also high, data_addr<=C_bus and the burst starts at C_bus;
//     - otherwise the burst starts at the current data_addr.
//   - load: data_addr<=C_bus; also clears err.
//   - inc: data_addr<=data_addr+STRIDE.
//   - dec: data_addr<=data_addr-STRIDE.
//   - none of the above: hold.
//   - burst_start with burst_len==0 is ignored entirely; load/inc/dec are then
//     evaluated as if burst_start were low.
//  BURST:
//   - load, inc, dec and burst_start are ignored.
//   - mem_ack=0: hold all state; mem_req stays high.
//   - mem_ack=1: data_addr<=data_addr+STRIDE, remaining<=remaining-1.
//   - mem_ack=1 with remaining==1: state->IDLE next cycle, done=1 for exactly that
//     one cycle, and data_addr = base + len*STRIDE.
//   - mem_ack while IDLE has no effect.
//  Latency: all address updates are visible the cycle after the command (1 clk).
//  Width and boundary rules:
//   - sums are computed ADDR_W+1 wide.
//   - WRAP_EN=1: result truncated to ADDR_W (mod 2**ADDR_W); err stays 0.
//   - WRAP_EN=0: overflow saturates data_addr at 2**ADDR_W-1 and sets err.
//   - WRAP_EN=0: underflow saturates data_addr at 0 and sets err.
//   - saturation during a burst does not stop the burst; the remaining count still
//     decrements per ack.
//   - err clears only on rst or on an accepted IDLE load.
//  Back-to-back bursts: burst_start asserted in the done cycle is accepted, because
//  the block is already IDLE in that cycle.
// TESTING
//  1 rst, then load=1 with C_bus=24'h00ABCD -> next cycle data_addr=24'h00ABCD,
//    busy=0, err=0.
//  2 data_addr=24'h000010, inc for 3 cycles, then dec for 1 cycle (STRIDE=1)
//    -> data_addr 11,12,13,12.
//  3 load+burst_start, C_bus=24'h000100, burst_len=4, mem_ack on alternate cycles
//    -> mem_req high throughout; acks seen at addrs 100,101,102,103; then
//    data_addr=24'h000104, done pulses once, busy=0.
//  4 wrap: data_addr=24'hFFFFFF, inc:
//    - WRAP_EN=1 -> 24'h000000, err=0;
//    - WRAP_EN=0 -> stays 24'hFFFFFF, err=1; a following load clears err.
//    - dec from 0 with WRAP_EN=0 -> 0, err=1.
//  5 rst asserted after 2 of 5 burst acks -> next cycle data_addr=0, busy=0,
//    mem_req=0; done never pulses.
//  6 burst_start with burst_len=0 -> stays IDLE, no done. load/inc during a burst
//    -> ignored, address sequence unchanged.

Source files
------------

// File: rtl/mar_burst.sv
// rtl/mar_burst.sv - memory address register with load, step and acknowledged burst modes
module mar_burst #(
    parameter int          ADDR_W  = 24,
    parameter int          LEN_W   = 8,
    parameter int unsigned STRIDE  = 1,
    parameter int          WRAP_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic              dec,
    input  logic [ADDR_W-1:0] C_bus,
    input  logic              burst_start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] data_addr,
    output logic              mem_req,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    // Step value widened by one bit so carry/borrow out is visible.
    localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(STRIDE);

    logic [0:0]        state, state_nxt;
    logic [LEN_W-1:0]  remaining, remaining_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              err_nxt;
    logic              done_nxt;

    logic [ADDR_W:0]   sum_up, sum_dn;
    logic [ADDR_W-1:0] up_addr, dn_addr;
    logic              up_err, dn_err;

    // Incremented and decremented address candidates, wrapping or saturating.
    always_comb begin
        sum_up = {1'b0, data_addr} + STEP;
        sum_dn = {1'b0, data_addr} - STEP;
        up_addr = sum_up[ADDR_W-1:0];
        up_err  = 1'b0;
        dn_addr = sum_dn[ADDR_W-1:0];
        dn_err  = 1'b0;
        if (WRAP_EN == 0 && sum_up[ADDR_W]) begin
            up_addr = '1;
            up_err  = 1'b1;
        end
        if (WRAP_EN == 0 && sum_dn[ADDR_W]) begin
            dn_addr = '0;
            dn_err  = 1'b1;
        end
    end

    // Next-state decode: IDLE commands by priority, BURST advances on ack.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        addr_nxt      = data_addr;
        err_nxt       = err;
        done_nxt      = 1'b0;
        if (state == S_IDLE) begin
            if (burst_start && burst_len != '0) begin
                state_nxt     = S_BURST;
                remaining_nxt = burst_len;
                if (load) begin
                    addr_nxt = C_bus;
                    err_nxt  = 1'b0;
                end
            end else if (load) begin
                addr_nxt = C_bus;
                err_nxt  = 1'b0;
            end else if (inc) begin
                addr_nxt = up_addr;
                err_nxt  = err | up_err;
            end else if (dec) begin
                addr_nxt = dn_addr;
                err_nxt  = err | dn_err;
            end
        end else if (mem_ack) begin
            addr_nxt      = up_addr;
            err_nxt       = err | up_err;
            remaining_nxt = remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
        end
    end

    // State registers with synchronous reset that aborts any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            data_addr <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            data_addr <= addr_nxt;
            err       <= err_nxt;
            done      <= done_nxt;
        end
    end

    assign busy    = (state == S_BURST);
    assign mem_req = (state == S_BURST);

endmodule

// File: tb/tb_mar_burst.sv
// tb/tb_mar_burst.sv - directed self-checking bench for mar_burst in wrap and saturate modes
module tb_mar_burst;

    logic        clk = 1'b0;
    logic        rst, load, inc, dec, burst_start, mem_ack;
    logic [23:0] C_bus;
    logic [7:0]  burst_len;

    logic [23:0] w_addr, s_addr;
    logic        w_req, w_busy, w_done, w_err;
    logic        s_req, s_busy, s_done, s_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mar_burst #(.ADDR_W(24), .LEN_W(8), .STRIDE(1), .WRAP_EN(1)) u_wrap (
        .clk(clk), .rst(rst), .load(load), .inc(inc), .dec(dec), .C_bus(C_bus),
        .burst_start(burst_start), .burst_len(burst_len), .mem_ack(mem_ack),
        .data_addr(w_addr), .mem_req(w_req), .busy(w_busy), .done(w_done), .err(w_err)
    );

    mar_burst #(.ADDR_W(24), .LEN_W(8), .STRIDE(1), .WRAP_EN(0)) u_sat (
        .clk(clk), .rst(rst), .load(load), .inc(inc), .dec(dec), .C_bus(C_bus),
        .burst_start(burst_start), .burst_len(burst_len), .mem_ack(mem_ack),
        .data_addr(s_addr), .mem_req(s_req), .busy(s_busy), .done(s_done), .err(s_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs;
        load = 0; inc = 0; dec = 0; burst_start = 0; burst_len = 0; mem_ack = 0;
    endtask

    initial begin
        rst = 1; C_bus = 0; idle_inputs();
        tick();
        rst = 0;
        chk("rst_addr", w_addr, 0);
        chk("rst_busy", w_busy, 0);
        chk("rst_req", w_req, 0);
        chk("rst_done", w_done, 0);
        chk("rst_err", s_err, 0);

        // 1: plain load
        load = 1; C_bus = 24'h00ABCD; tick(); load = 0;
        chk("load_addr", w_addr, 24'h00ABCD);
        chk("load_busy", w_busy, 0);
        chk("load_err", w_err, 0);

        // 2: inc x3 then dec
        load = 1; C_bus = 24'h000010; tick(); load = 0;
        inc = 1; tick(); chk("inc1", w_addr, 24'h11);
        tick(); chk("inc2", w_addr, 24'h12);
        tick(); chk("inc3", w_addr, 24'h13);
        inc = 0; dec = 1; tick(); chk("dec1", w_addr, 24'h12);
        dec = 0;

        // 3: load+burst of 4, acks on alternate cycles; load/inc ignored mid-burst
        load = 1; burst_start = 1; burst_len = 4; C_bus = 24'h000100; tick();
        idle_inputs();
        chk("bst_base", w_addr, 24'h100);
        chk("bst_busy", w_busy, 1);
        for (int k = 0; k < 4; k++) begin
            mem_ack = 0;
            if (k == 1 || k == 2) begin
                load = 1; inc = 1; C_bus = 24'h000555;
            end
            tick();
            load = 0; inc = 0;
            chk("bst_hold_addr", w_addr, 24'h100 + k);
            chk("bst_req", w_req, 1);
            chk("bst_nodone", w_done, 0);
            mem_ack = 1; tick();
            if (k < 3) begin
                chk("bst_mid_busy", w_busy, 1);
                chk("bst_mid_done", w_done, 0);
            end else begin
                chk("bst_end_addr", w_addr, 24'h104);
                chk("bst_end_done", w_done, 1);
                chk("bst_end_busy", w_busy, 0);
                chk("bst_end_req", w_req, 0);
            end
        end
        mem_ack = 0; tick();
        chk("bst_done_once", w_done, 0);

        // 6: zero-length burst ignored, inc evaluated instead
        burst_start = 1; burst_len = 0; tick();
        chk("len0_busy", w_busy, 0);
        chk("len0_addr", w_addr, 24'h104);
        inc = 1; tick(); idle_inputs();
        chk("len0_inc_addr", w_addr, 24'h105);
        chk("len0_inc_busy", w_busy, 0);
        chk("len0_done", w_done, 0);

        // 4: boundary wrap vs saturate
        load = 1; C_bus = 24'hFFFFFF; tick(); load = 0;
        inc = 1; tick(); inc = 0;
        chk("wrap_addr", w_addr, 24'h000000);
        chk("wrap_err", w_err, 0);
        chk("sat_hi_addr", s_addr, 24'hFFFFFF);
        chk("sat_hi_err", s_err, 1);
        inc = 1; tick(); inc = 0;
        chk("sat_err_sticky", s_err, 1);
        load = 1; C_bus = 24'h000005; tick(); load = 0;
        chk("sat_load_clr", s_err, 0);
        chk("sat_load_addr", s_addr, 24'h5);
        load = 1; C_bus = 24'h000000; tick(); load = 0;
        dec = 1; tick(); dec = 0;
        chk("sat_lo_addr", s_addr, 24'h0);
        chk("sat_lo_err", s_err, 1);
        chk("wrap_lo_addr", w_addr, 24'hFFFFFF);
        chk("wrap_lo_err", w_err, 0);

        // 5: reset after 2 of 5 acks
        load = 1; burst_start = 1; burst_len = 5; C_bus = 24'h000200; tick();
        idle_inputs();
        chk("rb_busy", s_busy, 1);
        chk("rb_err_clr", s_err, 0);
        mem_ack = 1; tick(); chk("rb_ack1", w_addr, 24'h201);
        tick(); chk("rb_ack2", w_addr, 24'h202);
        rst = 1; tick(); rst = 0; mem_ack = 0;
        chk("rb_addr", w_addr, 0);
        chk("rb_busy0", w_busy, 0);
        chk("rb_req0", w_req, 0);
        chk("rb_done0", w_done, 0);
        for (int k = 0; k < 4; k++) begin
            mem_ack = 1; tick();
            chk("rb_nodone", w_done, 0);
            chk("rb_idle_ack", w_addr, 0);
        end
        mem_ack = 0;

        // back-to-back: burst accepted in the done cycle
        load = 1; burst_start = 1; burst_len = 1; C_bus = 24'h000300; tick();
        idle_inputs();
        mem_ack = 1; tick(); mem_ack = 0;
        chk("b2b_done", w_done, 1);
        chk("b2b_addr", w_addr, 24'h301);
        burst_start = 1; burst_len = 2; tick(); idle_inputs();
        chk("b2b_busy", w_busy, 1);
        chk("b2b_base", w_addr, 24'h301);
        chk("b2b_done_low", w_done, 0);
        mem_ack = 1; tick(); tick(); mem_ack = 0;
        chk("b2b_end_addr", w_addr, 24'h303);
        chk("b2b_end_done", w_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
